// File: rtl/mips_pkg.sv
// Shared MIPS register-file types and defaults.
package mips_pkg;

    localparam int unsigned DW_DEFAULT = 32;
    localparam int unsigned AW_DEFAULT = 5;

    typedef logic [DW_DEFAULT-1:0] word_t;
    typedef logic [AW_DEFAULT-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One register-file read port: index mux, zero gating, write bypass,
// optional output register and busy lookup.
module regfile_read_port
    import mips_pkg::*;
#(
    parameter int unsigned DW       = DW_DEFAULT,
    parameter int unsigned AW       = AW_DEFAULT,
    parameter int unsigned REG_READ = 0,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned DEPTH   = 1 << AW
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [AW-1:0]    readIndex,
    input  logic [DW-1:0]    regs [DEPTH],
    input  logic [DEPTH-1:0] busyVec,
    input  logic             writeValid,
    input  logic [AW-1:0]    writeIndex,
    input  logic [DW-1:0]    writeData,
    output logic [DW-1:0]    readData,
    output logic             readBusy_c
);

    logic          isZero;
    logic          writeHit;
    logic [DW-1:0] bypassData;
    logic [DW-1:0] readDataQ;

    // A write landing this cycle is forwarded and hides the hazard.
    always_comb begin
        isZero     = (ZERO_REG != 0) && (readIndex == AW'(REG_ZERO));
        writeHit   = writeValid && (writeIndex == readIndex);
        bypassData = regs[readIndex];
        if (writeHit) begin
            bypassData = writeData;
        end
        if (isZero) begin
            bypassData = '0;
        end
        readBusy_c = busyVec[readIndex] && !writeHit;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            readDataQ <= '0;
        end else begin
            readDataQ <= bypassData;
        end
    end

    assign readData = (REG_READ != 0) ? readDataQ : bypassData;

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-read-port MIPS register file with write bypass, optional
// registered reads and a per-register busy scoreboard.
module mips_regfile_mp
    import mips_pkg::*;
#(
    parameter int unsigned DW       = DW_DEFAULT,
    parameter int unsigned AW       = AW_DEFAULT,
    parameter int unsigned NR       = 2,
    parameter int unsigned REG_READ = 0,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RegWrite,
    input  logic [AW-1:0]    WriteRegister,
    input  logic [DW-1:0]    WriteData,
    input  logic             IssueValid,
    input  logic [AW-1:0]    IssueRegister,
    input  logic [NR*AW-1:0] ReadRegister,
    output logic [NR*DW-1:0] ReadData,
    output logic [NR-1:0]    ReadBusy
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0]    regist [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busyNext;
    logic             writeValid;
    logic             issueValid;

    // Writes during reset are discarded along with everything else.
    always_comb begin
        writeValid = RegWrite && !RST &&
                     !((ZERO_REG != 0) && (WriteRegister == AW'(REG_ZERO)));
        issueValid = IssueValid &&
                     !((ZERO_REG != 0) && (IssueRegister == AW'(REG_ZERO)));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regist[i] <= '0;
            end
        end else if (writeValid) begin
            regist[WriteRegister] <= WriteData;
        end
    end

    // Set after clear: a same-cycle issue names a newer pending producer.
    always_comb begin
        busyNext = busy;
        if (writeValid) begin
            busyNext[WriteRegister] = 1'b0;
        end
        if (issueValid) begin
            busyNext[IssueRegister] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy <= '0;
        end else begin
            busy <= busyNext;
        end
    end

    for (genvar k = 0; k < int'(NR); k++) begin : gen_read
        regfile_read_port #(
            .DW       (DW),
            .AW       (AW),
            .REG_READ (REG_READ),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .CLK        (CLK),
            .RST        (RST),
            .readIndex  (ReadRegister[k*AW +: AW]),
            .regs       (regist),
            .busyVec    (busy),
            .writeValid (writeValid),
            .writeIndex (WriteRegister),
            .writeData  (WriteData),
            .readData   (ReadData[k*DW +: DW]),
            .readBusy_c (ReadBusy[k])
        );
    end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Bench for mips_regfile_mp: a combinational 4-port instance and a
// registered 2-port instance share stimulus and a behavioural model.
module tb_mips_regfile_mp;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RegWrite = 1'b0;
    logic [4:0]  WriteRegister = '0;
    logic [31:0] WriteData = '0;
    logic        IssueValid = 1'b0;
    logic [4:0]  IssueRegister = '0;
    logic [19:0] rr = '0;

    logic [127:0] rdC;
    logic [3:0]   busyC;
    logic [63:0]  rdR;
    logic [1:0]   busyR;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mips_regfile_mp #(.DW(32), .AW(5), .NR(4), .REG_READ(0), .ZERO_REG(1)) dutC (
        .CLK(CLK), .RST(RST), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .IssueValid(IssueValid), .IssueRegister(IssueRegister),
        .ReadRegister(rr), .ReadData(rdC), .ReadBusy(busyC));

    mips_regfile_mp #(.DW(32), .AW(5), .NR(2), .REG_READ(1), .ZERO_REG(1)) dutR (
        .CLK(CLK), .RST(RST), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .IssueValid(IssueValid), .IssueRegister(IssueRegister),
        .ReadRegister(rr[9:0]), .ReadData(rdR), .ReadBusy(busyR));

    // Behavioural model: architectural registers and pending-producer set.
    logic [31:0] mReg  [32];
    bit          mBusy [32];
    logic [31:0] mRegOut [2];

    function automatic bit writeLands(input logic [4:0] idx);
        return RegWrite && !RST && WriteRegister == idx && idx != 5'd0;
    endfunction

    function automatic logic [31:0] expData(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (writeLands(idx)) return WriteData;
        return mReg[idx];
    endfunction

    function automatic bit expBusy(input logic [4:0] idx);
        return mBusy[idx] && !writeLands(idx);
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) begin
                mReg[i]  = '0;
                mBusy[i] = 1'b0;
            end
            mRegOut[0] = '0;
            mRegOut[1] = '0;
        end else begin
            for (int k = 0; k < 2; k++) mRegOut[k] = expData(rr[k*5 +: 5]);
            if (RegWrite && WriteRegister != 5'd0) begin
                mReg[WriteRegister]  = WriteData;
                mBusy[WriteRegister] = 1'b0;
            end
            if (IssueValid && IssueRegister != 5'd0) mBusy[IssueRegister] = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge CLK) begin
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("cmp_dataC%0d", k), rdC[k*32 +: 32], expData(rr[k*5 +: 5]));
            chk($sformatf("cmp_busyC%0d", k), 32'(busyC[k]), 32'(expBusy(rr[k*5 +: 5])));
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("cmp_dataR%0d", k), rdR[k*32 +: 32], mRegOut[k]);
            chk($sformatf("cmp_busyR%0d", k), 32'(busyR[k]), 32'(expBusy(rr[k*5 +: 5])));
        end
    end

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic readAll(input logic [4:0] idx);
        rr = {idx, idx, idx, idx};
    endtask

    initial begin
        #3;
        chk("reset_dataC", rdC[31:0] | rdC[63:32] | rdC[95:64] | rdC[127:96], 32'h0);
        chk("reset_dataR", rdR[31:0] | rdR[63:32], 32'h0);
        chk("reset_busy", 32'({busyC, busyR}), 32'h0);
        @(negedge CLK); #1; RST = 1'b0;

        // Combinational write-through on r5
        nextCycle();
        RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 32'h12345678; readAll(5'd5);
        #2 chk("bypass_r5", rdC[31:0], 32'h12345678);
        nextCycle();
        RegWrite = 1'b0;
        #2 chk("hold_r5", rdC[31:0], 32'h12345678);

        // Registered read of r7 appears one cycle after the write
        nextCycle();
        RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 32'hA5A5A5A5; rr[4:0] = 5'd7;
        #2 chk("regread_before", rdR[31:0], 32'h12345678);
        nextCycle();
        RegWrite = 1'b0;
        #2 chk("regread_after", rdR[31:0], 32'hA5A5A5A5);

        // r0 ignores writes and issues
        nextCycle();
        RegWrite = 1'b1; WriteRegister = 5'd0; WriteData = 32'hDEADBEEF;
        IssueValid = 1'b1; IssueRegister = 5'd0; readAll(5'd0);
        #2 chk("r0_data_comb", rdC[31:0], 32'h0);
        nextCycle();
        RegWrite = 1'b0; IssueValid = 1'b0;
        #2 chk("r0_data_next", rdC[31:0], 32'h0);
        chk("r0_busy", 32'(busyC[0]), 32'h0);
        chk("r0_dataR", rdR[31:0], 32'h0);

        // Issue then writeback of r9
        nextCycle();
        IssueValid = 1'b1; IssueRegister = 5'd9; readAll(5'd9);
        #2 chk("issue_invisible", 32'(busyC), 32'h0);
        nextCycle();
        IssueValid = 1'b0;
        #2 chk("issue_busyC", 32'(busyC), 32'hF);
        chk("issue_busyR", 32'(busyR), 32'h3);
        nextCycle();
        RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 32'h00000099;
        #2 chk("wb_busy_clear", 32'(busyC), 32'h0);
        chk("wb_bypass", rdC[95:64], 32'h00000099);
        nextCycle();
        RegWrite = 1'b0;
        #2 chk("wb_busy_stays", 32'(busyC), 32'h0);

        // Same-cycle issue and write of r9: set wins
        nextCycle();
        IssueValid = 1'b1; IssueRegister = 5'd9;
        RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 32'h0BADF00D;
        #2 chk("setwin_now", 32'(busyC), 32'h0);
        nextCycle();
        IssueValid = 1'b0; RegWrite = 1'b0;
        #2 chk("setwin_busy", 32'(busyC), 32'hF);
        for (int k = 0; k < 4; k++) chk($sformatf("setwin_data%0d", k), rdC[k*32 +: 32], 32'h0BADF00D);

        // Mid-run reset with loaded state
        nextCycle();
        RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 32'h33;
        IssueValid = 1'b1; IssueRegister = 5'd4;
        nextCycle();
        RegWrite = 1'b0; IssueValid = 1'b0; rr = {5'd9, 5'd9, 5'd4, 5'd3};
        #1 chk("loaded_r3", rdC[31:0], 32'h33);
        chk("loaded_busy_r4", 32'(busyC[1]), 32'h1);
        RST = 1'b1;
        #1 chk("rst_dataC", rdC[31:0] | rdC[63:32] | rdC[95:64] | rdC[127:96], 32'h0);
        chk("rst_dataR", rdR[31:0] | rdR[63:32], 32'h0);
        chk("rst_busy", 32'({busyC, busyR}), 32'h0);
        @(negedge CLK); #1; RST = 1'b0;
        nextCycle();
        #1 chk("post_rst_r3", rdC[31:0], 32'h0);

        // Directed mixed traffic, checked every cycle by the compare process
        for (int i = 0; i < 40; i++) begin
            nextCycle();
            RegWrite      = (i % 3) != 0;
            WriteRegister = 5'((i * 7) % 8);
            WriteData     = 32'h1000_0000 + 32'(i * 32'h01010101);
            IssueValid    = (i % 2) == 0;
            IssueRegister = 5'((i * 5) % 8);
            rr = {5'((i + 3) % 8), 5'((i * 3) % 8), 5'(i % 8), 5'((i * 7) % 8)};
        end
        nextCycle();
        RegWrite = 1'b0; IssueValid = 1'b0;
        repeat (2) nextCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
